y86_data_mem_ctrl: RTL and testbench
====================================

Name: y86_data_mem_ctrl

Overview:
Parametrised Y86 data memory for the memory stage, with a request/response handshake.
- Byte-addressed, little-endian, 64-bit word storage.
- Unaligned accesses are split into two word accesses by an internal FSM.
- Out-of-range addresses are flagged on rsp_err, which feeds the stage's dmem_error status.
- Sits between the memory-stage address/data muxes and the write-back stage.

Parameters:
- DEPTH_WORDS, 1024: number of 64-bit words stored; must be a power of 2, 2 or more.
- ADDR_W, 64: width of the byte address input.
- ALLOW_UNALIGNED, 1: 1 = split unaligned accesses; 0 = any address with addr[2:0] != 0 raises rsp_err.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  64  write data, little-endian.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  64  read data; 0 for writes and for errors.
- rsp_err  out  1  address error (becomes dmem_error).

Behaviour:
- Interface (already decided): one clock, clk; reset is rst_n, asynchronous and active-low.
- Reset values:
  - state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - Memory array contents are not reset.
- Address decode:
  - word index = addr[3 +: log2(DEPTH_WORDS)]; byte offset off = addr[2:0].
  - The range check uses full ADDR_W+1-bit arithmetic.
  - Error if addr + 8 > DEPTH_WORDS*8, or if addr + 8 overflows ADDR_W bits.
  - Error if off != 0 and ALLOW_UNALIGNED = 0.
- Handshake:
  - A request is accepted on a cycle with req_valid && req_ready.
  - Request fields are captured at acceptance; later changes to them are ignored.
  - req_ready = 1 only in IDLE, so at most one transaction is in flight.
- FSM states: IDLE, SECOND, RESP.
  - IDLE, accept with error: no array write; load rsp_err = 1, rsp_rdata = 0; go to RESP.
  - IDLE, accept, off == 0: perform the full word read or write this edge; load rsp_rdata (read data, or 0 for a write); go to RESP.
  - IDLE, accept, off != 0: access low word W.
    - Write: W bytes [off..7] <- wdata bytes [0..7-off].
    - Read: latch W bytes [off..7] into rdata bytes [0..7-off].
    - Go to SECOND.
  - SECOND: access word W+1.
    - Write: W+1 bytes [0..off-1] <- wdata bytes [8-off..7].
    - Read: rdata bytes [8-off..7] <- W+1 bytes [0..off-1].
    - Go to RESP.
  - RESP: rsp_valid = 1; rsp_rdata and rsp_err held stable. On rsp_ready go to IDLE and drop rsp_valid.
- Latency from the acceptance edge:
  - Aligned or error: rsp_valid is 1 in the next cycle.
  - Unaligned: rsp_valid is 1 two cycles later.
  - Minimum request-to-request spacing is 2 cycles aligned, 3 cycles unaligned.
- Byte enables: a write changes only its target bytes; all other bytes of the touched words are preserved.
- Reset mid-operation:
  - In SECOND: the low-word bytes already written remain; the high word is not written; no response is issued.
  - In RESP: the pending response is discarded.
- rsp_ready while not in RESP has no effect.

Test Plan:
1. Aligned write addr 0x10, data 0x1122334455667788, then read 0x10 -> rsp_rdata = 0x1122334455667788, rsp_err = 0, rsp_valid in the cycle after each acceptance.
2. Zero-fill words 0x08 and 0x10; write 0x0D, data 0xA8A7A6A5A4A3A2A1 ->
   - read 0x08 returns 0xA3A2A10000000000;
   - read 0x10 returns 0x000000A8A7A6A5A4;
   - read 0x0D returns 0xA8A7A6A5A4A3A2A1;
   - rsp_valid 2 cycles after acceptance.
3. With DEPTH_WORDS = 1024:
   - read 0x1FF8 -> err 0.
   - write 0x1FF9 -> rsp_err = 1, rsp_rdata = 0.
   - read 0x1FF8 afterwards -> unchanged.
   - addr 0xFFFFFFFFFFFFFFFC -> rsp_err = 1.
4. Hold rsp_ready low 3 cycles after a read response -> rsp_valid, rsp_rdata and rsp_err stable, and req_ready = 0 throughout; raise rsp_ready -> IDLE next cycle, req_ready = 1.
5. Start unaligned write 0x0D of 0xFFFF_FFFF_FFFF_FFFF onto zeroed words; assert rst_n low during SECOND -> rsp_valid = 0; word 0x08 = 0xFFFFFF0000000000; word 0x10 = 0.
6. With ALLOW_UNALIGNED = 0, read 0x0C -> rsp_err = 1 after 1 cycle, no array access.

Source files
------------

// File: rtl/y86_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// y86_data_mem_ctrl : Y86 memory-stage data memory, little-endian 64-bit words,
// request/response handshake, unaligned accesses split over two cycles.
// Revision: 1.0
// ============================================================================
module y86_data_mem_ctrl #(
  parameter int DEPTH_WORDS     = 1024,
  parameter int ADDR_W          = 64,
  parameter int ALLOW_UNALIGNED = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [63:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int LW = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W:0] LIM_BYTES = (ADDR_W+1)'(DEPTH_WORDS) << 3;

  typedef enum logic [1:0] {IDLE, SECOND, RESP} state_t;

  state_t          state_q;
  logic            req_ready_q;
  logic            rsp_valid_q;
  logic [63:0]     rsp_rdata_q;
  logic            rsp_err_q;
  logic            wr_q;
  logic [2:0]      off_q;
  logic [LW-1:0]   hi_idx_q;
  logic [63:0]     wdata_q;
  logic [63:0]     mem_q [DEPTH_WORDS];

  logic [LW-1:0]   w_idx;
  logic [2:0]      w_off;
  logic [ADDR_W:0] w_end;
  logic            w_err;
  logic [63:0]     w_rd_lo;
  logic [63:0]     w_rd_hi;
  logic            w_we;
  logic [LW-1:0]   w_widx;
  logic [7:0]      w_wmask;
  logic [63:0]     w_wdata;

  assign w_idx = req_addr[3 +: LW];
  assign w_off = req_addr[2:0];
  // Extra carry bit catches addresses whose +8 wraps the ADDR_W space.
  assign w_end = {1'b0, req_addr} + (ADDR_W+1)'(8);
  assign w_err = w_end[ADDR_W] || (w_end > LIM_BYTES) ||
                 ((ALLOW_UNALIGNED == 0) && (w_off != 3'd0));

  assign w_rd_lo = mem_q[w_idx] >> {w_off, 3'b000};
  assign w_rd_hi = mem_q[hi_idx_q] << (7'd64 - {1'b0, off_q, 3'b000});

  always_comb begin
    w_we    = 1'b0;
    w_widx  = w_idx;
    w_wmask = 8'h00;
    w_wdata = 64'd0;
    if (state_q == IDLE && req_valid && req_wr && !w_err) begin
      w_we    = 1'b1;
      w_widx  = w_idx;
      w_wmask = 8'hFF << w_off;
      w_wdata = req_wdata << {w_off, 3'b000};
    end else if (state_q == SECOND && wr_q) begin
      w_we    = 1'b1;
      w_widx  = hi_idx_q;
      w_wmask = ~(8'hFF << off_q);
      w_wdata = wdata_q >> (7'd64 - {1'b0, off_q, 3'b000});
    end
  end

  // Gated by rst_n so an edge seen while reset is held never touches the array.
  always_ff @(posedge clk) begin
    if (w_we && rst_n) begin
      for (int b = 0; b < 8; b++) begin
        if (w_wmask[b]) mem_q[w_widx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 64'd0;
      rsp_err_q   <= 1'b0;
      wr_q        <= 1'b0;
      off_q       <= 3'd0;
      hi_idx_q    <= '0;
      wdata_q     <= 64'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            req_ready_q <= 1'b0;
            wr_q        <= req_wr;
            off_q       <= w_off;
            hi_idx_q    <= w_idx + 1'b1;
            wdata_q     <= req_wdata;
            rsp_err_q   <= w_err;
            rsp_rdata_q <= (w_err || req_wr) ? 64'd0 : w_rd_lo;
            if (w_err || w_off == 3'd0) begin
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              state_q     <= SECOND;
            end
          end
        end
        SECOND: begin
          if (!wr_q) rsp_rdata_q <= rsp_rdata_q | w_rd_hi;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_y86_data_mem_ctrl.sv
`default_nettype none
// Directed bench for y86_data_mem_ctrl: a default instance plus an aligned-only one.
module tb_y86_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_wr = 1'b0;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;

  logic        req_valid_a = 1'b0, rsp_ready_a = 1'b0;
  logic        req_ready_a, rsp_valid_a, rsp_err_a;
  logic [63:0] rsp_rdata_a;

  logic        req_valid_b = 1'b0, rsp_ready_b = 1'b0;
  logic        req_ready_b, rsp_valid_b, rsp_err_b;
  logic [63:0] rsp_rdata_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  y86_data_mem_ctrl #(.DEPTH_WORDS(1024), .ADDR_W(64), .ALLOW_UNALIGNED(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a),
    .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a)
  );

  y86_data_mem_ctrl #(.DEPTH_WORDS(16), .ADDR_W(64), .ALLOW_UNALIGNED(0)) dut_na (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
    .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b)
  );

  // Drives one request to instance a (sel=0) or b (sel=1); scrambles the request
  // fields after acceptance; returns the response and the acceptance-to-valid latency.
  task automatic xact(input bit sel, input bit wr, input logic [63:0] addr,
                      input logic [63:0] wdata, input bit consume,
                      output logic [63:0] rd, output logic err, output int lat);
    @(negedge clk);
    req_wr = wr; req_addr = addr; req_wdata = wdata;
    if (sel) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    @(posedge clk);
    #1;
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    req_wr = ~wr; req_addr = ~addr; req_wdata = ~wdata;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(sel ? rsp_valid_b : rsp_valid_a) && lat < 20);
    rd  = sel ? rsp_rdata_b : rsp_rdata_a;
    err = sel ? rsp_err_b : rsp_err_a;
    if (consume) begin
      if (sel) rsp_ready_b = 1'b1; else rsp_ready_a = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready_a = 1'b0; rsp_ready_b = 1'b0;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if (req_ready_a !== 1'b1 || rsp_valid_a !== 1'b0 || rsp_rdata_a !== 64'd0 || rsp_err_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ready=%b valid=%b rdata=%h err=%b, want 1 0 0 0",
               req_ready_a, rsp_valid_a, rsp_rdata_a, rsp_err_a);
    end
  endtask

  task automatic test_aligned;
    logic [63:0] rd; logic err; int lat;
    xact(0, 1, 64'h10, 64'h1122334455667788, 1, rd, err, lat);
    checks++;
    if (lat !== 1 || err !== 1'b0 || rd !== 64'd0) begin
      errors++;
      $display("FAIL aligned_wr: lat=%0d err=%b rd=%h, want 1 0 0", lat, err, rd);
    end
    xact(0, 0, 64'h10, 64'h0, 1, rd, err, lat);
    checks++;
    if (lat !== 1 || err !== 1'b0 || rd !== 64'h1122334455667788) begin
      errors++;
      $display("FAIL aligned_rd: lat=%0d err=%b rd=%h, want 1 0 1122334455667788", lat, err, rd);
    end
    @(negedge clk);
    checks++;
    if (req_ready_a !== 1'b1 || rsp_valid_a !== 1'b0) begin
      errors++;
      $display("FAIL aligned_idle: ready=%b valid=%b, want 1 0", req_ready_a, rsp_valid_a);
    end
  endtask

  task automatic test_unaligned;
    logic [63:0] rd; logic err; int lat;
    xact(0, 1, 64'h08, 64'h0, 1, rd, err, lat);
    xact(0, 1, 64'h10, 64'h0, 1, rd, err, lat);
    xact(0, 1, 64'h0D, 64'hA8A7A6A5A4A3A2A1, 1, rd, err, lat);
    checks++;
    if (lat !== 2 || err !== 1'b0 || rd !== 64'd0) begin
      errors++;
      $display("FAIL unal_wr: lat=%0d err=%b rd=%h, want 2 0 0", lat, err, rd);
    end
    xact(0, 0, 64'h08, 64'h0, 1, rd, err, lat);
    checks++;
    if (rd !== 64'hA3A2A10000000000 || err !== 1'b0) begin
      errors++;
      $display("FAIL unal_lo_word: rd=%h err=%b, want a3a2a10000000000 0", rd, err);
    end
    xact(0, 0, 64'h10, 64'h0, 1, rd, err, lat);
    checks++;
    if (rd !== 64'h000000A8A7A6A5A4 || err !== 1'b0) begin
      errors++;
      $display("FAIL unal_hi_word: rd=%h err=%b, want 000000a8a7a6a5a4 0", rd, err);
    end
    xact(0, 0, 64'h0D, 64'h0, 1, rd, err, lat);
    checks++;
    if (lat !== 2 || rd !== 64'hA8A7A6A5A4A3A2A1 || err !== 1'b0) begin
      errors++;
      $display("FAIL unal_rd: lat=%0d rd=%h err=%b, want 2 a8a7a6a5a4a3a2a1 0", lat, rd, err);
    end
  endtask

  task automatic test_range;
    logic [63:0] rd; logic err; int lat;
    xact(0, 1, 64'h1FF8, 64'hCAFEF00D12345678, 1, rd, err, lat);
    xact(0, 0, 64'h1FF8, 64'h0, 1, rd, err, lat);
    checks++;
    if (err !== 1'b0 || rd !== 64'hCAFEF00D12345678) begin
      errors++;
      $display("FAIL range_last_word: err=%b rd=%h, want 0 cafef00d12345678", err, rd);
    end
    xact(0, 1, 64'h1FF9, 64'hFFFFFFFFFFFFFFFF, 1, rd, err, lat);
    checks++;
    if (lat !== 1 || err !== 1'b1 || rd !== 64'd0) begin
      errors++;
      $display("FAIL range_wr_1ff9: lat=%0d err=%b rd=%h, want 1 1 0", lat, err, rd);
    end
    xact(0, 0, 64'h1FF8, 64'h0, 1, rd, err, lat);
    checks++;
    if (err !== 1'b0 || rd !== 64'hCAFEF00D12345678) begin
      errors++;
      $display("FAIL range_unchanged: err=%b rd=%h, want 0 cafef00d12345678", err, rd);
    end
    xact(0, 0, 64'hFFFFFFFFFFFFFFFC, 64'h0, 1, rd, err, lat);
    checks++;
    if (lat !== 1 || err !== 1'b1 || rd !== 64'd0) begin
      errors++;
      $display("FAIL range_wrap_fc: lat=%0d err=%b rd=%h, want 1 1 0", lat, err, rd);
    end
    xact(0, 0, 64'h2000, 64'h0, 1, rd, err, lat);
    checks++;
    if (err !== 1'b1 || rd !== 64'd0) begin
      errors++;
      $display("FAIL range_2000: err=%b rd=%h, want 1 0", err, rd);
    end
  endtask

  task automatic test_backpressure;
    logic [63:0] rd; logic err; int lat;
    xact(0, 0, 64'h10, 64'h0, 0, rd, err, lat);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid_a !== 1'b1 || rsp_rdata_a !== 64'h000000A8A7A6A5A4 ||
          rsp_err_a !== 1'b0 || req_ready_a !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: valid=%b rdata=%h err=%b ready=%b, want 1 000000a8a7a6a5a4 0 0",
                 i, rsp_valid_a, rsp_rdata_a, rsp_err_a, req_ready_a);
      end
    end
    rsp_ready_a = 1'b1;
    @(posedge clk);
    #1 rsp_ready_a = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid_a !== 1'b0 || req_ready_a !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: valid=%b ready=%b, want 0 1", rsp_valid_a, req_ready_a);
    end
  endtask

  task automatic test_reset_mid;
    logic [63:0] rd; logic err; int lat;
    xact(0, 1, 64'h08, 64'h0, 1, rd, err, lat);
    xact(0, 1, 64'h10, 64'h0, 1, rd, err, lat);
    @(negedge clk);
    req_wr = 1'b1; req_addr = 64'h0D; req_wdata = 64'hFFFFFFFFFFFFFFFF; req_valid_a = 1'b1;
    @(posedge clk);
    #1 req_valid_a = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid_a !== 1'b0 || req_ready_a !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_state: valid=%b ready=%b, want 0 1", rsp_valid_a, req_ready_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (rsp_valid_a !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_norsp: valid=%b, want 0", rsp_valid_a);
    end
    xact(0, 0, 64'h08, 64'h0, 1, rd, err, lat);
    checks++;
    if (rd !== 64'hFFFFFF0000000000) begin
      errors++;
      $display("FAIL rst_mid_lo: rd=%h, want ffffff0000000000", rd);
    end
    xact(0, 0, 64'h10, 64'h0, 1, rd, err, lat);
    checks++;
    if (rd !== 64'd0) begin
      errors++;
      $display("FAIL rst_mid_hi: rd=%h, want 0", rd);
    end
  endtask

  task automatic test_no_unaligned;
    logic [63:0] rd; logic err; int lat;
    xact(1, 1, 64'h08, 64'h0123456789ABCDEF, 1, rd, err, lat);
    checks++;
    if (lat !== 1 || err !== 1'b0) begin
      errors++;
      $display("FAIL na_aligned_wr: lat=%0d err=%b, want 1 0", lat, err);
    end
    xact(1, 0, 64'h0C, 64'h0, 1, rd, err, lat);
    checks++;
    if (lat !== 1 || err !== 1'b1 || rd !== 64'd0) begin
      errors++;
      $display("FAIL na_rd_0c: lat=%0d err=%b rd=%h, want 1 1 0", lat, err, rd);
    end
    xact(1, 1, 64'h0C, 64'hFFFFFFFFFFFFFFFF, 1, rd, err, lat);
    xact(1, 0, 64'h08, 64'h0, 1, rd, err, lat);
    checks++;
    if (err !== 1'b0 || rd !== 64'h0123456789ABCDEF) begin
      errors++;
      $display("FAIL na_untouched: err=%b rd=%h, want 0 0123456789abcdef", err, rd);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_aligned();
    test_unaligned();
    test_range();
    test_backpressure();
    test_reset_mid();
    test_no_unaligned();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
